// File: rtl/alu_ctrl.sv
// Sequencer that decodes an op index into ALU select lines, waits for the ALU to settle,
// then captures result/carry/zero. Optional zero flag: define ALU_CTRL_ZERO_FLAG_EN.
module alu_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  input  logic [7:0] alu_data,
  input  logic       alu_carry,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       s4,
  output logic [7:0] result,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       result_we,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] OP_MAX    = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  result_q, result_d;
  logic        carry_q, carry_d;
  logic [4:0]  sel;

  // instr[7:4] is reserved; folded into a sink so it is visibly ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^instr[7:4];

  // {s0,s1,s2,s3,s4} per op index; out-of-range never reaches EXEC.
  function automatic logic [4:0] sel_map(input logic [3:0] op);
    case (op)
      4'd0:    sel_map = 5'b00000;
      4'd1:    sel_map = 5'b10000;
      4'd2:    sel_map = 5'b01000;
      4'd3:    sel_map = 5'b11000;
      4'd4:    sel_map = 5'b00110;
      4'd5:    sel_map = 5'b00101;
      4'd6:    sel_map = 5'b00001;
      4'd7:    sel_map = 5'b00100;
      4'd8:    sel_map = 5'b00010;
      default: sel_map = 5'b00000;
    endcase
  endfunction

`ifdef ALU_CTRL_ZERO_FLAG_EN
  logic zero_q, zero_d;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
`ifdef ALU_CTRL_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = instr[3:0];
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (op_q <= OP_MAX) begin
          state_d = EXEC;
          cnt_d   = SETTLE_LD;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // Capture on the edge leaving the last settle cycle.
        if (cnt_q <= 4'd1) begin
          state_d  = WB;
          cnt_d    = 4'd0;
          result_d = alu_data;
          carry_d  = alu_carry;
`ifdef ALU_CTRL_ZERO_FLAG_EN
          zero_d   = (alu_data == 8'h00);
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 4'd0;
      cnt_q    <= 4'd0;
      result_q <= 8'h00;
      carry_q  <= 1'b0;
`ifdef ALU_CTRL_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
`ifdef ALU_CTRL_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  // Outputs are pure functions of registered state, so reset clears them too.
  assign sel         = (state_q == EXEC || state_q == WB) ? sel_map(op_q) : 5'b00000;
  assign {s0, s1, s2, s3, s4} = sel;
  assign instr_ready = (state_q == IDLE);
  assign illegal     = (state_q == DECODE) && (op_q > OP_MAX);
  assign done        = (state_q == WB);
  assign result_we   = (state_q == WB);
  assign result      = result_q;
  assign carry_flag  = carry_q;
`ifdef ALU_CTRL_ZERO_FLAG_EN
  assign zero_flag   = zero_q;
`else
  assign zero_flag   = 1'b0;
`endif

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, range 1..15: number of cycles the select lines are held before the ALU result is captured.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port instr_valid, input, 1: instruction offered.
REQ-005 SHALL have port instr, input, 8: instr[3:0] is the op index; instr[7:4] is reserved and ignored.
REQ-006 SHALL have port instr_ready, output, 1: block can accept an instruction.
REQ-007 SHALL have ports alu_data, input, 8, and alu_carry, input, 1: result and carry returned by the ALU.
REQ-008 SHALL have ports s0, s1, s2, s3, s4, output, 1 each: ALU select lines.
REQ-009 SHALL have port result, output, 8: last captured ALU result.
REQ-010 SHALL have port carry_flag, output, 1: last captured carry.
REQ-011 SHALL have port zero_flag, output, 1: last captured result equal to 0x00; see Configuration.
REQ-012 SHALL have port result_we, output, 1: one-cycle pulse when result is updated.
REQ-013 SHALL have port done, output, 1: one-cycle pulse marking a completed legal instruction.
REQ-014 SHALL have port illegal, output, 1: one-cycle pulse marking a rejected op index.

Function
REQ-015 SHALL implement four states: IDLE, DECODE, EXEC and WB.
REQ-016 SHALL assert instr_ready only in IDLE, and SHALL accept an instruction on a rising edge with instr_valid=1 and instr_ready=1, registering instr[3:0] and moving to DECODE.
REQ-017 SHALL leave instr_valid without effect outside IDLE, so a held request is accepted only after the block returns to IDLE.
REQ-018 SHALL, in DECODE, move to EXEC for op index 0..8; for 9..15 it SHALL return to IDLE, pulse illegal for that one cycle, and leave result and flags unchanged.
REQ-019 SHALL map op index to {s0,s1,s2,s3,s4} as follows: 0=00000, 1=10000, 2=01000, 3=11000, 4=00110, 5=00101, 6=00001, 7=00100, 8=00010.
REQ-020 SHALL drive the selects from the registered op index during EXEC and WB only, and SHALL drive all selects 0 in IDLE and DECODE.
REQ-021 SHALL stay in EXEC for exactly SETTLE_CYCLES cycles, counted by a 4-bit counter loaded on entry to EXEC.
REQ-022 SHALL, on the edge that leaves the last EXEC cycle, capture result<=alu_data, carry_flag<=alu_carry and zero_flag<=(alu_data==0x00), then enter WB.
REQ-023 SHALL assert result_we and done during WB for exactly one cycle, then return to IDLE unconditionally.
REQ-024 SHALL deliver done in the cycle after the (SETTLE_CYCLES+2)-th rising edge counted from the accept edge; with the default SETTLE_CYCLES this is three edges after accept.
REQ-025 SHALL hold result and the flags stable between captures.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, enter IDLE and clear the EXEC counter, result (0x00), carry_flag, zero_flag, result_we, done, illegal and s0..s4 to 0.
REQ-027 SHALL have instr_ready=1 in the first cycle after reset deasserts.
REQ-028 SHALL discard any in-flight instruction when reset occurs mid-operation, with no done, result_we or illegal pulse for it.
REQ-029 SHALL let rst take priority over instruction acceptance on the same edge.

Configuration
REQ-030 SHALL, with ALU_CTRL_ZERO_FLAG_EN defined, implement zero_flag as described in REQ-022.
REQ-031 SHALL, without ALU_CTRL_ZERO_FLAG_EN, tie zero_flag to 0 with no register inferred; all other behaviour is identical.

Verification
REQ-032 SHALL cover this scenario: defaults, instr=0x01, bench ALU model returns 0x17 with carry=1 -> {s0..s4}=10000 in EXEC, done and result_we pulse three edges after accept, result=0x17, carry_flag=1.
REQ-033 SHALL cover this scenario: instr=0x0C -> illegal pulses one cycle after accept, no result_we or done, result keeps its prior value, instr_ready returns the next cycle.
REQ-034 SHALL cover this scenario: SETTLE_CYCLES=4, instr=0x04 -> selects=00110 held four cycles, done six edges after accept.
REQ-035 SHALL cover this scenario: rst=1 in EXEC after instr=0x03 -> selects=00000, result=0x00, no done pulse, instr_ready=1 one cycle after rst falls.
REQ-036 SHALL cover this scenario: instr_valid held high across two instructions 0x02 then 0x07 -> the second is accepted only in IDLE after the first done, with selects 01000 then 00100.
REQ-037 SHALL cover this scenario: ALU model returns 0x00 for instr=0x05 -> zero_flag=1 with ALU_CTRL_ZERO_FLAG_EN defined, and 0 without it.
